// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with a valid bit per slot, hold, flush, load-use bubble insertion
// and a saturating bubble counter.
`timescale 1ns/1ps
module id_ex_pipe_stage #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 18,
    parameter int REG_AW    = 5,
    parameter int MEMRD_BIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ID_Valid,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [DATA_W-1:0] ID_PCAddResult,
    input  logic [DATA_W-1:0] ID_Read1,
    input  logic [DATA_W-1:0] ID_Read2,
    input  logic [DATA_W-1:0] ID_SignExtend,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              ID_UsesRt,
    input  logic              Stall_In,
    input  logic              Flush,
    output logic              EX_Valid,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [DATA_W-1:0] EX_PCAddResult,
    output logic [DATA_W-1:0] EX_Read1,
    output logic [DATA_W-1:0] EX_Read2,
    output logic [DATA_W-1:0] EX_SignExtend,
    output logic [REG_AW-1:0] EX_Rs,
    output logic [REG_AW-1:0] EX_Rt,
    output logic [REG_AW-1:0] EX_Rd,
    output logic              LoadUse_Hazard,
    output logic [CNT_W-1:0]  Bubble_Count
);

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_read1_q, ex_read1_d;
    logic [DATA_W-1:0] ex_read2_q, ex_read2_d;
    logic [DATA_W-1:0] ex_sext_q, ex_sext_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;
    logic              hit_s;
    logic              bubble_s;

    // Load in EX whose destination (never r0) feeds a source of the decode instruction
    always_comb begin
        hit_s = ex_valid_q & ex_ctrl_q[MEMRD_BIT] & (ex_rt_q != {REG_AW{1'b0}}) &
                ((ex_rt_q == ID_Rs) | (ID_UsesRt & (ex_rt_q == ID_Rt)));
    end

    assign LoadUse_Hazard = hit_s & ID_Valid & ~Flush;
    assign bubble_s       = Flush | (hit_s & ID_Valid);

    // Next-state selection: hold beats flush beats load-use bubble beats normal load
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_pc_d        = ex_pc_q;
        ex_read1_d     = ex_read1_q;
        ex_read2_d     = ex_read2_q;
        ex_sext_d      = ex_sext_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_rd_d        = ex_rd_q;
        bubble_count_d = bubble_count_q;
        if (Stall_In) begin
            ex_valid_d = ex_valid_q;
        end else begin
            // Data and specifiers load even for a bubble; only valid/ctrl are squashed
            ex_pc_d    = ID_PCAddResult;
            ex_read1_d = ID_Read1;
            ex_read2_d = ID_Read2;
            ex_sext_d  = ID_SignExtend;
            ex_rs_d    = ID_Rs;
            ex_rt_d    = ID_Rt;
            ex_rd_d    = ID_Rd;
            if (bubble_s) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = {CTRL_W{1'b0}};
                if (bubble_count_q != {CNT_W{1'b1}}) begin
                    bubble_count_d = bubble_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    bubble_count_d = bubble_count_q;
                end
            end else begin
                ex_valid_d = ID_Valid;
                ex_ctrl_d  = ID_Ctrl;
            end
        end
    end

    // Stage registers with asynchronous clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= {CTRL_W{1'b0}};
            ex_pc_q        <= {DATA_W{1'b0}};
            ex_read1_q     <= {DATA_W{1'b0}};
            ex_read2_q     <= {DATA_W{1'b0}};
            ex_sext_q      <= {DATA_W{1'b0}};
            ex_rs_q        <= {REG_AW{1'b0}};
            ex_rt_q        <= {REG_AW{1'b0}};
            ex_rd_q        <= {REG_AW{1'b0}};
            bubble_count_q <= {CNT_W{1'b0}};
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_pc_q        <= ex_pc_d;
            ex_read1_q     <= ex_read1_d;
            ex_read2_q     <= ex_read2_d;
            ex_sext_q      <= ex_sext_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign EX_Valid       = ex_valid_q;
    assign EX_Ctrl        = ex_ctrl_q;
    assign EX_PCAddResult = ex_pc_q;
    assign EX_Read1       = ex_read1_q;
    assign EX_Read2       = ex_read2_q;
    assign EX_SignExtend  = ex_sext_q;
    assign EX_Rs          = ex_rs_q;
    assign EX_Rt          = ex_rt_q;
    assign EX_Rd          = ex_rd_q;
    assign Bubble_Count   = bubble_count_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: stimulus pushes the expected EX state per edge,
// a monitor pops and compares after each rising edge.
`timescale 1ns/1ps
module tb_id_ex_pipe_stage;

    localparam int DW = 32;
    localparam int CW = 18;
    localparam int AW = 5;
    localparam int NW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          ID_Valid = 1'b0;
    logic [CW-1:0] ID_Ctrl = '0;
    logic [DW-1:0] ID_PCAddResult = '0, ID_Read1 = '0, ID_Read2 = '0, ID_SignExtend = '0;
    logic [AW-1:0] ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
    logic          ID_UsesRt = 1'b0, Stall_In = 1'b0, Flush = 1'b0;
    logic          EX_Valid;
    logic [CW-1:0] EX_Ctrl;
    logic [DW-1:0] EX_PCAddResult, EX_Read1, EX_Read2, EX_SignExtend;
    logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd;
    logic          LoadUse_Hazard;
    logic [NW-1:0] Bubble_Count;

    id_ex_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .REG_AW(AW), .MEMRD_BIT(4), .CNT_W(NW)) dut (
        .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Ctrl(ID_Ctrl),
        .ID_PCAddResult(ID_PCAddResult), .ID_Read1(ID_Read1), .ID_Read2(ID_Read2),
        .ID_SignExtend(ID_SignExtend), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_UsesRt(ID_UsesRt), .Stall_In(Stall_In), .Flush(Flush),
        .EX_Valid(EX_Valid), .EX_Ctrl(EX_Ctrl), .EX_PCAddResult(EX_PCAddResult),
        .EX_Read1(EX_Read1), .EX_Read2(EX_Read2), .EX_SignExtend(EX_SignExtend),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .LoadUse_Hazard(LoadUse_Hazard), .Bubble_Count(Bubble_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc, r1, r2, se;
        logic [AW-1:0] rs, rt, rd;
        int            cnt;
    } ex_t;

    ex_t m;
    ex_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m = '{valid: 1'b0, ctrl: '0, pc: '0, r1: '0, r2: '0, se: '0, rs: '0, rt: '0, rd: '0, cnt: 0};
    endtask

    function automatic bit model_hit();
        return m.valid && m.ctrl[4] && m.rt != 0 &&
               (m.rt == ID_Rs || (ID_UsesRt && m.rt == ID_Rt));
    endfunction

    // Called just after inputs change at a falling edge; checks the hazard, predicts the edge, ends at next falling edge
    task automatic apply();
        bit hz;
        #1;
        hz = model_hit() && ID_Valid && !Flush;
        chk("hazard", {63'd0, LoadUse_Hazard}, {63'd0, hz});
        if (!Stall_In) begin
            m.pc = ID_PCAddResult; m.r1 = ID_Read1; m.r2 = ID_Read2; m.se = ID_SignExtend;
            if (Flush || (model_hit() && ID_Valid)) begin
                m.valid = 1'b0;
                m.ctrl  = '0;
                if (m.cnt < (1 << NW) - 1) m.cnt = m.cnt + 1;
            end else begin
                m.valid = ID_Valid;
                m.ctrl  = ID_Ctrl;
            end
            m.rs = ID_Rs; m.rt = ID_Rt; m.rd = ID_Rd;
        end
        exp_q.push_back(m);
        @(negedge Clk);
    endtask

    // Monitor: one expected EX state per rising edge
    always @(posedge Clk) begin
        ex_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("EX_Valid", {63'd0, EX_Valid}, {63'd0, e.valid});
            chk("EX_Ctrl", {46'd0, EX_Ctrl}, {46'd0, e.ctrl});
            chk("EX_PCAddResult", {32'd0, EX_PCAddResult}, {32'd0, e.pc});
            chk("EX_Read1", {32'd0, EX_Read1}, {32'd0, e.r1});
            chk("EX_Read2", {32'd0, EX_Read2}, {32'd0, e.r2});
            chk("EX_SignExtend", {32'd0, EX_SignExtend}, {32'd0, e.se});
            chk("EX_Rs", {59'd0, EX_Rs}, {59'd0, e.rs});
            chk("EX_Rt", {59'd0, EX_Rt}, {59'd0, e.rt});
            chk("EX_Rd", {59'd0, EX_Rd}, {59'd0, e.rd});
            chk("Bubble_Count", {60'd0, Bubble_Count}, 64'(e.cnt));
        end
    end

    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        chk("rst_valid", {63'd0, EX_Valid}, 64'd0);
        chk("rst_ctrl", {46'd0, EX_Ctrl}, 64'd0);
        chk("rst_data", {EX_Read1, EX_Read2 | EX_PCAddResult | EX_SignExtend}, 64'd0);
        chk("rst_regs", {49'd0, EX_Rs, EX_Rt, EX_Rd}, 64'd0);
        chk("rst_count", {60'd0, Bubble_Count}, 64'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt, input logic [AW-1:0] rd, input logic u);
        ID_Valid = v; ID_Ctrl = c; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = u;
        ID_PCAddResult = $urandom; ID_Read1 = $urandom; ID_Read2 = $urandom; ID_SignExtend = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge Clk);
        do_reset();

        // Reset then plain load
        set_id(1'b1, 18'h000A5, 5'd1, 5'd2, 5'd5, 1'b1);
        ID_Read1 = 32'h12345678;
        apply();
        chk("load_valid", {63'd0, EX_Valid}, 64'd1);
        chk("load_ctrl", {46'd0, EX_Ctrl}, 64'h00A5);
        chk("load_read1", {32'd0, EX_Read1}, 64'h12345678);
        chk("load_rd", {59'd0, EX_Rd}, 64'd5);

        // Load-use on rs: one bubble, then the held instruction enters
        set_id(1'b1, 18'h00010, 5'd3, 5'd8, 5'd8, 1'b0);
        apply();
        set_id(1'b1, 18'h00001, 5'd8, 5'd3, 5'd9, 1'b1);
        #1 chk("lu_hazard", {63'd0, LoadUse_Hazard}, 64'd1);
        apply();
        chk("lu_bubble_valid", {63'd0, EX_Valid}, 64'd0);
        chk("lu_bubble_ctrl", {46'd0, EX_Ctrl}, 64'd0);
        chk("lu_bubble_count", {60'd0, Bubble_Count}, 64'd1);
        apply();
        chk("lu_after_valid", {63'd0, EX_Valid}, 64'd1);
        chk("lu_after_ctrl", {46'd0, EX_Ctrl}, 64'd1);

        // rt match but rt not a source: no hazard
        set_id(1'b1, 18'h00010, 5'd3, 5'd8, 5'd8, 1'b0);
        apply();
        set_id(1'b1, 18'h00002, 5'd2, 5'd8, 5'd4, 1'b0);
        #1 chk("norts_hazard", {63'd0, LoadUse_Hazard}, 64'd0);
        apply();
        chk("norts_valid", {63'd0, EX_Valid}, 64'd1);

        // Register zero never triggers
        set_id(1'b1, 18'h00010, 5'd3, 5'd0, 5'd0, 1'b0);
        apply();
        set_id(1'b1, 18'h00003, 5'd0, 5'd0, 5'd6, 1'b1);
        #1 chk("r0_hazard", {63'd0, LoadUse_Hazard}, 64'd0);
        apply();
        chk("r0_valid", {63'd0, EX_Valid}, 64'd1);

        // Stall beats flush and hazard; then flush alone bubbles
        set_id(1'b1, 18'h00010, 5'd3, 5'd8, 5'd8, 1'b0);
        apply();
        set_id(1'b1, 18'h00004, 5'd8, 5'd8, 5'd7, 1'b1);
        Stall_In = 1'b1; Flush = 1'b1;
        for (int i = 0; i < 3; i++) apply();
        chk("stall_rt", {59'd0, EX_Rt}, 64'd8);
        chk("stall_count", {60'd0, Bubble_Count}, 64'd1);
        Stall_In = 1'b0;
        #1 chk("flush_mask", {63'd0, LoadUse_Hazard}, 64'd0);
        apply();
        chk("flush_valid", {63'd0, EX_Valid}, 64'd0);
        chk("flush_count", {60'd0, Bubble_Count}, 64'd2);

        // Saturation: 19 bubbles from a cleared counter
        Flush = 1'b0;
        do_reset();
        Flush = 1'b1;
        for (int i = 0; i < 19; i++) begin
            set_id(1'b1, 18'(i), 5'(i), 5'd1, 5'd2, 1'b1);
            apply();
            if (i == 14) chk("sat_15", {60'd0, Bubble_Count}, 64'hF);
        end
        chk("sat_19", {60'd0, Bubble_Count}, 64'hF);
        Flush = 1'b0;
        do_reset();

        // Randomized traffic, biased to small register numbers so hazards are frequent
        for (int n = 0; n < 2000; n++) begin
            logic v;
            logic [CW-1:0] c;
            v = ($urandom_range(0, 9) < 8);
            c = v ? CW'($urandom) : '0;
            set_id(v, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom), 1'($urandom));
            Stall_In = ($urandom_range(0, 9) < 2);
            Flush    = ($urandom_range(0, 19) < 3);
            if ($urandom_range(0, 199) == 0) do_reset();
            else apply();
        end
        Stall_In = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage register that supersedes the fixed-field ID/EX register.
- Adds the following over the fixed-field version:
  - per-slot valid bit
  - downstream stall (hold)
  - flush (kill)
  - integrated load-use hazard detection with automatic one-cycle bubble insertion
  - saturating bubble counter for performance debug
- Sits between the decode stage (register file read, sign extend, control unit) and the execute stage. Its hazard output drives the PC and IF/ID write-enables.

Parameters:
- DATA_W, 32: width of PC+4, register read data and sign-extended immediate.
- CTRL_W, 18: width of the packed control bundle (WB, MEM and EX fields, concatenated by the decoder).
- REG_AW, 5: register-specifier width.
- MEMRD_BIT, 4: bit index within the control bundle that flags a memory-read (load) instruction.
- CNT_W, 16: bubble counter width.

Ports:
- Clk  in  1  clock
- Reset  in  1  async active-high reset
- ID_Valid  in  1  decode slot holds a real instruction
- ID_Ctrl  in  CTRL_W  packed control bundle
- ID_PCAddResult  in  DATA_W  PC+4
- ID_Read1  in  DATA_W  rs read data
- ID_Read2  in  DATA_W  rt read data
- ID_SignExtend  in  DATA_W  extended immediate
- ID_Rs  in  REG_AW  rs specifier
- ID_Rt  in  REG_AW  rt specifier
- ID_Rd  in  REG_AW  rd specifier
- ID_UsesRt  in  1  decode instruction reads rt as a source
- Stall_In  in  1  downstream stall; EX must hold
- Flush  in  1  kill the decode-slot instruction (branch/jump resolved)
- EX_Valid  out  1  execute slot valid
- EX_Ctrl  out  CTRL_W  registered control bundle
- EX_PCAddResult  out  DATA_W  registered PC+4
- EX_Read1  out  DATA_W  registered rs data
- EX_Read2  out  DATA_W  registered rt data
- EX_SignExtend  out  DATA_W  registered immediate
- EX_Rs  out  REG_AW  registered rs specifier
- EX_Rt  out  REG_AW  registered rt specifier
- EX_Rd  out  REG_AW  registered rd specifier
- LoadUse_Hazard  out  1  combinational; deassert PC and IF/ID write-enables
- Bubble_Count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Interface: Reset is asynchronous, active-high; Clk is the clock. All registers update on posedge Clk.
- Reset: every output register goes to 0 immediately, including EX_Valid, EX_Ctrl, all data and specifier fields, and Bubble_Count.
- Hazard (combinational):
  - hit = EX_Valid & EX_Ctrl[MEMRD_BIT] & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & EX_Rt == ID_Rt)).
  - LoadUse_Hazard = hit & ID_Valid & !Flush.
  - A killed instruction never stalls the front end.
- Per-edge priority (exactly one action applies):
  1. Stall_In = 1 → HOLD: all EX_* registers keep their values; Bubble_Count unchanged. Stall_In overrides Flush and the hazard.
  2. else Flush = 1 → BUBBLE.
  3. else hit & ID_Valid → BUBBLE. The decode instruction is not lost: upstream holds it because LoadUse_Hazard = 1.
  4. else → LOAD: all EX_* registers take the ID_* values; EX_Valid <= ID_Valid.
- BUBBLE:
  - EX_Valid <= 0 and EX_Ctrl <= 0.
  - Data and specifier registers still load from ID_* (their values are don't-care when invalid, but the load is defined so benches can check it).
  - Bubble_Count increments by 1 unless it is all ones (saturates; no wrap).
- Latency: one cycle from ID to EX for LOAD.
- A load-use bubble lasts exactly one cycle. After the bubble EX_Valid = 0, so hit drops and the held instruction is loaded on the next edge.
- ID_Valid = 0 with no stall or flush is a LOAD of an invalid slot: EX_Ctrl still takes ID_Ctrl, and Bubble_Count does not increment. The decoder is required to supply ID_Ctrl = 0 for an invalid slot.
- Register 0 never triggers a hazard.
- Reset asserted during a stall or bubble clears all state; the first edge after release performs a normal priority evaluation.

Test Plan:
- Reset then LOAD: assert Reset mid-cycle → all outputs 0 asynchronously. Release; drive ID_Valid = 1, ID_Ctrl = 0x00A5, ID_Read1 = 0x12345678, ID_Rd = 5 → one edge later EX_Valid = 1, EX_Ctrl = 0x00A5, EX_Read1 = 0x12345678, EX_Rd = 5.
- Load-use:
  - EX holds a load (EX_Ctrl[4] = 1, EX_Rt = 8, EX_Valid = 1); ID_Rs = 8 → LoadUse_Hazard = 1.
  - Next edge: EX_Valid = 0, EX_Ctrl = 0, Bubble_Count = 1.
  - Following edge (ID unchanged): EX_Valid = 1 with ID values.
  - Repeat with ID_Rt = 8 and ID_UsesRt = 0 → no hazard.
- Zero register: load with EX_Rt = 0 and ID_Rs = 0 → LoadUse_Hazard = 0; a LOAD occurs.
- Stall priority: Stall_In = 1 together with Flush = 1 and a hazard for 3 cycles → EX_* unchanged on every edge and Bubble_Count unchanged. Drop Stall_In with Flush still 1 → BUBBLE, and Bubble_Count increments.
- Flush masking: a hazard condition together with Flush = 1 → LoadUse_Hazard = 0; next edge EX_Valid = 0, EX_Ctrl = 0.
- Saturation: force 2^CNT_W + 3 bubbles (use CNT_W = 4: 19 bubbles) → Bubble_Count = 0xF after the 15th bubble and stays 0xF.
